// File: rtl/ofs_fim_eth_plat_if_pkg.sv
// Shared Ethernet platform types: MAC sideband struct, PFC priority count
// and the pause-generator state encoding.
package ofs_fim_eth_plat_if_pkg;

    localparam int ETH_PFC_PRIO = 8;

    typedef struct packed {
        logic                    pause_xoff;
        logic                    pause_xon;
        logic [ETH_PFC_PRIO-1:0] pfc_xoff;
    } t_eth_sideband_to_mac;

    typedef enum logic {
        PAUSE_IDLE,
        PAUSE_ACTIVE
    } t_eth_pause_state;

endpackage

// File: rtl/eth_pause_sideband_gen.sv
// Per-channel 802.3x XOFF/XON generator with hysteresis and periodic XOFF
// refresh, plus registered PFC pass-through onto the MAC sideband.
module eth_pause_sideband_gen
    import ofs_fim_eth_plat_if_pkg::*;
#(
    parameter int FILL_W         = 12,
    parameter int XOFF_THRESH    = 768,
    parameter int XON_THRESH     = 256,
    parameter int REFRESH_W      = 16,
    parameter int REFRESH_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_pause_en,
    input  logic                    cfg_pfc_en,
    input  logic [FILL_W-1:0]       fill_level,
    input  logic                    fill_valid,
    input  logic [ETH_PFC_PRIO-1:0] pfc_req,
    output t_eth_sideband_to_mac    sb_to_mac,
    output logic                    paused,
    output logic [15:0]             xoff_events
);

    if (!(XON_THRESH < XOFF_THRESH) || ((XOFF_THRESH >> FILL_W) != 0) ||
        (REFRESH_CYCLES < 2) || (((REFRESH_CYCLES - 1) >> REFRESH_W) != 0)) begin : g_bad_params
        $error("eth_pause_sideband_gen: illegal threshold/refresh parameters");
    end

    localparam logic [FILL_W-1:0]    XOFF_LVL = FILL_W'(XOFF_THRESH);
    localparam logic [FILL_W-1:0]    XON_LVL  = FILL_W'(XON_THRESH);
    localparam logic [REFRESH_W-1:0] RELOAD   = REFRESH_W'(REFRESH_CYCLES - 1);

    t_eth_pause_state     r_state;
    t_eth_pause_state     w_next_state;
    logic [FILL_W-1:0]    r_fill_q;
    logic [REFRESH_W-1:0] r_timer;
    logic [REFRESH_W-1:0] w_timer_next;
    logic                 w_xoff;
    logic                 w_xon;
    t_eth_sideband_to_mac r_sb;
    logic                 r_paused;
    logic [15:0]          r_xoff_events;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_next_state = r_state;
        w_timer_next = r_timer;
        w_xoff       = 1'b0;
        w_xon        = 1'b0;
        case (r_state)
            PAUSE_IDLE: begin
                if (cfg_pause_en && (r_fill_q >= XOFF_LVL)) begin
                    w_next_state = PAUSE_ACTIVE;
                    w_xoff       = 1'b1;
                    w_timer_next = RELOAD;
                end
            end
            PAUSE_ACTIVE: begin
                // Disabling pause takes priority so the link partner is always released.
                if (!cfg_pause_en || (r_fill_q <= XON_LVL)) begin
                    w_next_state = PAUSE_IDLE;
                    w_xon        = 1'b1;
                    w_timer_next = '0;
                end else if (r_timer == '0) begin
                    w_xoff       = 1'b1;
                    w_timer_next = RELOAD;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            default: w_next_state = PAUSE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; a reset while paused just zeroes the outputs, no XON.
        if (rst) begin
            r_state       <= PAUSE_IDLE;
            r_fill_q      <= '0;
            r_timer       <= '0;
            r_sb          <= '0;
            r_paused      <= 1'b0;
            r_xoff_events <= '0;
        end else begin
            if (fill_valid) begin
                r_fill_q <= fill_level;
            end
            r_state         <= w_next_state;
            r_timer         <= w_timer_next;
            r_paused        <= (w_next_state == PAUSE_ACTIVE);
            r_sb.pause_xoff <= w_xoff;
            r_sb.pause_xon  <= w_xon;
            r_sb.pfc_xoff   <= pfc_req & {ETH_PFC_PRIO{cfg_pfc_en}};
            if (w_xoff && (r_xoff_events != 16'hFFFF)) begin
                r_xoff_events <= r_xoff_events + 1'b1;
            end
        end
    end

    assign sb_to_mac   = r_sb;
    assign paused      = r_paused;
    assign xoff_events = r_xoff_events;

endmodule

// File: tb/tb_eth_pause_sideband_gen.sv
// Directed bench for eth_pause_sideband_gen: XOFF/XON hysteresis, refresh
// period, enable gating, PFC pass-through, reset and counter saturation.
module tb_eth_pause_sideband_gen;
    import ofs_fim_eth_plat_if_pkg::*;

    localparam int FILL_W  = 12;
    localparam int REFRESH = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_pause_en;
    logic                 cfg_pfc_en;
    logic [FILL_W-1:0]    fill_level;
    logic                 fill_valid;
    logic [7:0]           pfc_req;
    t_eth_sideband_to_mac sb_to_mac;
    logic                 paused;
    logic [15:0]          xoff_events;

    int n_checks = 0;
    int n_errors = 0;
    int n_xoff_seen = 0;
    int n_xon_seen = 0;

    eth_pause_sideband_gen #(
        .FILL_W(FILL_W), .XOFF_THRESH(768), .XON_THRESH(256),
        .REFRESH_W(16), .REFRESH_CYCLES(REFRESH)
    ) dut (
        .clk(clk), .rst(rst), .cfg_pause_en(cfg_pause_en), .cfg_pfc_en(cfg_pfc_en),
        .fill_level(fill_level), .fill_valid(fill_valid), .pfc_req(pfc_req),
        .sb_to_mac(sb_to_mac), .paused(paused), .xoff_events(xoff_events)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and tally the pulses visible there.
    task automatic step();
        @(negedge clk);
        if (sb_to_mac.pause_xoff) n_xoff_seen++;
        if (sb_to_mac.pause_xon)  n_xon_seen++;
        if (sb_to_mac.pause_xoff && sb_to_mac.pause_xon) begin
            n_errors++;
            $display("FAIL xoff_xon_overlap: both pause bits high at %0t", $time);
        end
    endtask

    task automatic wait_pulse(input bit want_xon, input int max_steps, output int n);
        n = 0;
        while (1) begin
            step();
            n++;
            if (want_xon ? sb_to_mac.pause_xon : sb_to_mac.pause_xoff) break;
            if (n >= max_steps) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_pause_en = 1'b1; cfg_pfc_en = 1'b0;
        fill_level = '0; fill_valid = 1'b0; pfc_req = '0;
        step(); step();
        rst = 1'b0;
        step();
        n_checks++;
        if (sb_to_mac !== 10'h000) begin n_errors++; $display("FAIL reset_sb: got %h want 000", sb_to_mac); end
        n_checks++;
        if (paused !== 1'b0) begin n_errors++; $display("FAIL reset_paused: got %b want 0", paused); end
        n_checks++;
        if (xoff_events !== 16'h0000) begin n_errors++; $display("FAIL reset_events: got %h want 0000", xoff_events); end
    endtask

    task automatic test_xoff();
        fill_level = 12'd800; fill_valid = 1'b1;
        step();
        n_checks++;
        if (sb_to_mac.pause_xoff !== 1'b0) begin n_errors++; $display("FAIL xoff_early: got %b want 0", sb_to_mac.pause_xoff); end
        step();
        n_checks++;
        if (sb_to_mac.pause_xoff !== 1'b1) begin n_errors++; $display("FAIL xoff_pulse: got %b want 1", sb_to_mac.pause_xoff); end
        n_checks++;
        if (paused !== 1'b1) begin n_errors++; $display("FAIL xoff_paused: got %b want 1", paused); end
        n_checks++;
        if (xoff_events !== 16'd1) begin n_errors++; $display("FAIL xoff_events: got %0d want 1", xoff_events); end
    endtask

    task automatic test_refresh();
        int n;
        int xon0;
        xon0 = n_xon_seen;
        for (int r = 0; r < 4; r++) begin
            wait_pulse(1'b0, 40, n);
            n_checks++;
            if (n !== REFRESH) begin n_errors++; $display("FAIL refresh_gap%0d: got %0d cycles want %0d", r, n, REFRESH); end
        end
        n_checks++;
        if (xoff_events !== 16'd5) begin n_errors++; $display("FAIL refresh_events: got %0d want 5", xoff_events); end
        n_checks++;
        if (n_xon_seen != xon0) begin n_errors++; $display("FAIL refresh_xon: got %0d pulses want 0", n_xon_seen - xon0); end
    endtask

    task automatic test_hysteresis();
        int n;
        int xoff0;
        int xon0;
        xoff0 = n_xoff_seen; xon0 = n_xon_seen;
        fill_level = 12'd500;
        repeat (8) step();
        n_checks++;
        if ((n_xoff_seen != xoff0) || (n_xon_seen != xon0)) begin
            n_errors++; $display("FAIL hyst_mid_pulses: got xoff %0d xon %0d want 0 0", n_xoff_seen - xoff0, n_xon_seen - xon0);
        end
        n_checks++;
        if (paused !== 1'b1) begin n_errors++; $display("FAIL hyst_mid_paused: got %b want 1", paused); end
        fill_level = 12'd256;
        wait_pulse(1'b1, 10, n);
        n_checks++;
        if (n !== 2) begin n_errors++; $display("FAIL hyst_xon_latency: got %0d want 2", n); end
        n_checks++;
        if (paused !== 1'b0) begin n_errors++; $display("FAIL hyst_xon_paused: got %b want 0", paused); end
        step();
        n_checks++;
        if (sb_to_mac.pause_xon !== 1'b0) begin n_errors++; $display("FAIL hyst_xon_width: got %b want 0", sb_to_mac.pause_xon); end
        xoff0 = n_xoff_seen;
        fill_level = 12'd767;
        repeat (20) step();
        n_checks++;
        if (n_xoff_seen != xoff0) begin n_errors++; $display("FAIL hyst_767_xoff: got %0d pulses want 0", n_xoff_seen - xoff0); end
        n_checks++;
        if (xoff_events !== 16'd5) begin n_errors++; $display("FAIL hyst_events: got %0d want 5", xoff_events); end
    endtask

    task automatic test_disable();
        int n;
        int xoff0;
        fill_level = 12'd800;
        wait_pulse(1'b0, 10, n);
        n_checks++;
        if (n !== 2) begin n_errors++; $display("FAIL dis_xoff_latency: got %0d want 2", n); end
        cfg_pause_en = 1'b0;
        wait_pulse(1'b1, 10, n);
        n_checks++;
        if (n !== 1) begin n_errors++; $display("FAIL dis_xon_latency: got %0d want 1", n); end
        n_checks++;
        if (paused !== 1'b0) begin n_errors++; $display("FAIL dis_paused: got %b want 0", paused); end
        xoff0 = n_xoff_seen;
        fill_level = 12'd1000;
        repeat (20) step();
        n_checks++;
        if (n_xoff_seen != xoff0) begin n_errors++; $display("FAIL dis_xoff: got %0d pulses want 0", n_xoff_seen - xoff0); end
        n_checks++;
        if (xoff_events !== 16'd6) begin n_errors++; $display("FAIL dis_events: got %0d want 6", xoff_events); end
        fill_level = 12'd0;
        step(); step();
        cfg_pause_en = 1'b1;
        step(); step();
    endtask

    task automatic test_pfc();
        pfc_req = 8'hA5; cfg_pfc_en = 1'b1;
        step();
        n_checks++;
        if (sb_to_mac.pfc_xoff !== 8'hA5) begin n_errors++; $display("FAIL pfc_a5: got %h want a5", sb_to_mac.pfc_xoff); end
        n_checks++;
        if (sb_to_mac[9:8] !== 2'b00) begin n_errors++; $display("FAIL pfc_pause_bits: got %b want 00", sb_to_mac[9:8]); end
        pfc_req = 8'h5A;
        step();
        n_checks++;
        if (sb_to_mac.pfc_xoff !== 8'h5A) begin n_errors++; $display("FAIL pfc_5a: got %h want 5a", sb_to_mac.pfc_xoff); end
        cfg_pfc_en = 1'b0;
        step();
        n_checks++;
        if (sb_to_mac.pfc_xoff !== 8'h00) begin n_errors++; $display("FAIL pfc_disabled: got %h want 00", sb_to_mac.pfc_xoff); end
        pfc_req = 8'h00;
    endtask

    task automatic test_reset_mid_paused();
        int n;
        int xon0;
        fill_level = 12'd800;
        wait_pulse(1'b0, 10, n);
        n_checks++;
        if (xoff_events !== 16'd7) begin n_errors++; $display("FAIL rstmid_events_pre: got %0d want 7", xoff_events); end
        repeat (5) step();
        xon0 = n_xon_seen;
        rst = 1'b1; fill_level = 12'd0;
        step();
        n_checks++;
        if (sb_to_mac !== 10'h000) begin n_errors++; $display("FAIL rstmid_sb: got %h want 000", sb_to_mac); end
        n_checks++;
        if (paused !== 1'b0) begin n_errors++; $display("FAIL rstmid_paused: got %b want 0", paused); end
        n_checks++;
        if (xoff_events !== 16'd0) begin n_errors++; $display("FAIL rstmid_events: got %0d want 0", xoff_events); end
        rst = 1'b0;
        step(); step();
        n_checks++;
        if (n_xon_seen != xon0) begin n_errors++; $display("FAIL rstmid_xon: got %0d pulses want 0", n_xon_seen - xon0); end
    endtask

    task automatic test_saturation();
        int n;
        force dut.r_xoff_events = 16'hFFFF;
        step();
        release dut.r_xoff_events;
        step();
        n_checks++;
        if (xoff_events !== 16'hFFFF) begin n_errors++; $display("FAIL sat_preload: got %h want ffff", xoff_events); end
        fill_level = 12'd800;
        wait_pulse(1'b0, 10, n);
        n_checks++;
        if (n !== 2) begin n_errors++; $display("FAIL sat_xoff_latency: got %0d want 2", n); end
        n_checks++;
        if (xoff_events !== 16'hFFFF) begin n_errors++; $display("FAIL sat_events: got %h want ffff", xoff_events); end
    endtask

    initial begin
        test_reset();
        test_xoff();
        test_refresh();
        test_hysteresis();
        test_disable();
        test_pfc();
        test_reset_mid_paused();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
